// File: rtl/light_track_pkg.sv
// Shared types and helpers for the light_track tug-of-war game.
package light_track_pkg;

    typedef enum logic [1:0] {
        PLAY = 2'd0,
        LWIN = 2'd1,
        RWIN = 2'd2
    } state_e;

    // Reset/restart light position for an n-light track.
    function automatic int unsigned center_pos(input int unsigned n);
        return n / 2;
    endfunction

endpackage

// File: rtl/light_track_press_detect.sv
// Single-bit rising-edge press detector; a level held through reset never counts as a press.
module press_detect (
    input  logic Clock,
    input  logic Reset,
    input  logic in_i,
    output logic press_c_o
);

    logic prev_q;
    logic armed_q;

    // armed_q blocks the first post-reset sample so a press needs a seen 0 then 1.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            prev_q  <= in_i;
            armed_q <= 1'b1;
        end
    end

    assign press_c_o = armed_q & in_i & ~prev_q;

endmodule

// File: rtl/light_track.sv
// Tug-of-war light track: two buttons push a single light left or right, with win counting.
module light_track
    import light_track_pkg::*;
#(
    parameter int unsigned N     = 9,
    parameter int unsigned WRAP  = 0,
    parameter int unsigned CNT_W = 4
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             left_btn,
    input  logic             right_btn,
    input  logic             restart,
    output logic [N-1:0]     leds,
    output logic             left_win,
    output logic             right_win,
    output logic [CNT_W-1:0] left_score,
    output logic [CNT_W-1:0] right_score
);

    localparam int unsigned PW = $clog2(N);
    localparam logic [PW-1:0] CENTER  = PW'(center_pos(N));
    localparam logic [PW-1:0] POS_MAX = PW'(N - 1);
    localparam logic [CNT_W-1:0] SCORE_MAX = {CNT_W{1'b1}};

    logic left_press_c;
    logic right_press_c;

    press_detect u_left_press (
        .Clock     (Clock),
        .Reset     (Reset),
        .in_i      (left_btn),
        .press_c_o (left_press_c)
    );

    press_detect u_right_press (
        .Clock     (Clock),
        .Reset     (Reset),
        .in_i      (right_btn),
        .press_c_o (right_press_c)
    );

    state_e           state_q, state_d;
    logic [PW-1:0]    pos_q, pos_d;
    logic [CNT_W-1:0] lscore_q, lscore_d;
    logic [CNT_W-1:0] rscore_q, rscore_d;

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state_q  <= PLAY;
            pos_q    <= CENTER;
            lscore_q <= '0;
            rscore_q <= '0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            lscore_q <= lscore_d;
            rscore_q <= rscore_d;
        end
    end

    // Restart overrides play; simultaneous presses cancel out.
    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        lscore_d = lscore_q;
        rscore_d = rscore_q;
        if (restart) begin
            state_d = PLAY;
            pos_d   = CENTER;
        end else if (state_q == PLAY) begin
            if (left_press_c && !right_press_c) begin
                if (pos_q != POS_MAX) begin
                    pos_d = pos_q + PW'(1);
                end else if (WRAP != 0) begin
                    pos_d = '0;
                end else begin
                    state_d = LWIN;
                    if (lscore_q != SCORE_MAX) begin
                        lscore_d = lscore_q + CNT_W'(1);
                    end
                end
            end else if (right_press_c && !left_press_c) begin
                if (pos_q != '0) begin
                    pos_d = pos_q - PW'(1);
                end else if (WRAP != 0) begin
                    pos_d = POS_MAX;
                end else begin
                    state_d = RWIN;
                    if (rscore_q != SCORE_MAX) begin
                        rscore_d = rscore_q + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_comb begin
        leds        = '0;
        leds[pos_q] = 1'b1;
    end

    assign left_win    = (state_q == LWIN);
    assign right_win   = (state_q == RWIN);
    assign left_score  = lscore_q;
    assign right_score = rscore_q;

endmodule

// File: tb/tb_light_track.sv
// Scoreboard bench for light_track: three configurations driven by shared stimulus.
module tb_light_track;

    logic Clock = 1'b0;
    logic Reset, left_btn, right_btn, restart;

    always #5 Clock = ~Clock;

    logic [8:0] leds0, leds1, leds2;
    logic       lw0, rw0, lw1, rw1, lw2, rw2;
    logic [3:0] ls0, rs0, ls1, rs1;
    logic [1:0] ls2, rs2;

    light_track #(.N(9), .WRAP(0), .CNT_W(4)) dut0 (
        .Clock(Clock), .Reset(Reset), .left_btn(left_btn), .right_btn(right_btn),
        .restart(restart), .leds(leds0), .left_win(lw0), .right_win(rw0),
        .left_score(ls0), .right_score(rs0));

    light_track #(.N(9), .WRAP(1), .CNT_W(4)) dut1 (
        .Clock(Clock), .Reset(Reset), .left_btn(left_btn), .right_btn(right_btn),
        .restart(restart), .leds(leds1), .left_win(lw1), .right_win(rw1),
        .left_score(ls1), .right_score(rs1));

    light_track #(.N(9), .WRAP(0), .CNT_W(2)) dut2 (
        .Clock(Clock), .Reset(Reset), .left_btn(left_btn), .right_btn(right_btn),
        .restart(restart), .leds(leds2), .left_win(lw2), .right_win(rw2),
        .left_score(ls2), .right_score(rs2));

    typedef struct {
        int pos;
        int st;     // 0 play, 1 left won, 2 right won
        int ls;
        int rs;
        bit pl;
        bit pr;
        bit armed;
    } mdl_t;

    typedef struct {
        logic [8:0] leds;
        bit         lw;
        bit         rw;
        int         ls;
        int         rs;
    } exp_t;

    mdl_t mdl [3];
    exp_t exp_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic mdl_t mstep(input mdl_t m, input bit rst, input bit l, input bit r,
                                   input bit rs, input bit wrap, input int smax);
        bit lp, rp;
        if (!rst) begin
            m = '{pos: 4, st: 0, ls: 0, rs: 0, pl: 0, pr: 0, armed: 0};
            return m;
        end
        lp = m.armed && l && !m.pl;
        rp = m.armed && r && !m.pr;
        m.pl = l;
        m.pr = r;
        m.armed = 1'b1;
        if (rs) begin
            m.pos = 4;
            m.st  = 0;
        end else if (m.st == 0 && lp && !rp) begin
            if (m.pos < 8) m.pos++;
            else if (wrap) m.pos = 0;
            else begin
                m.st = 1;
                if (m.ls < smax) m.ls++;
            end
        end else if (m.st == 0 && rp && !lp) begin
            if (m.pos > 0) m.pos--;
            else if (wrap) m.pos = 8;
            else begin
                m.st = 2;
                if (m.rs < smax) m.rs++;
            end
        end
        return m;
    endfunction

    task automatic cmp_one(input int k, input exp_t e, input logic [8:0] leds, input bit lw,
                           input bit rw, input int ls, input int rs);
        check_eq($sformatf("d%0d.leds", k), 32'(leds), 32'(e.leds));
        check_eq($sformatf("d%0d.lwin", k), 32'(lw), 32'(e.lw));
        check_eq($sformatf("d%0d.rwin", k), 32'(rw), 32'(e.rw));
        check_eq($sformatf("d%0d.lscore", k), 32'(ls), 32'(e.ls));
        check_eq($sformatf("d%0d.rscore", k), 32'(rs), 32'(e.rs));
        check_eq($sformatf("d%0d.onehot", k), 32'($onehot(leds)), 32'd1);
    endtask

    // Drive one cycle, push model expectations, then compare after the edge.
    task automatic cyc(input bit l, input bit r, input bit rs, input bit rst);
        exp_t e;
        @(negedge Clock);
        left_btn  = l;
        right_btn = r;
        restart   = rs;
        Reset     = rst;
        for (int k = 0; k < 3; k++) begin
            mdl[k] = mstep(mdl[k], rst, l, r, rs, k == 1, (k == 2) ? 3 : 15);
            e.leds = 9'(1) << mdl[k].pos;
            e.lw   = (mdl[k].st == 1);
            e.rw   = (mdl[k].st == 2);
            e.ls   = mdl[k].ls;
            e.rs   = mdl[k].rs;
            exp_q.push_back(e);
        end
        @(posedge Clock);
        #1;
        if (exp_q.size() < 3) begin
            check_eq("sb.underflow", 32'(exp_q.size()), 32'd3);
        end else begin
            cmp_one(0, exp_q.pop_front(), leds0, lw0, rw0, 32'(ls0), 32'(rs0));
            cmp_one(1, exp_q.pop_front(), leds1, lw1, rw1, 32'(ls1), 32'(rs1));
            cmp_one(2, exp_q.pop_front(), leds2, lw2, rw2, 32'(ls2), 32'(rs2));
        end
    endtask

    task automatic press_left();
        cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 1);
    endtask

    task automatic press_right();
        cyc(0, 1, 0, 1);
        cyc(0, 0, 0, 1);
    endtask

    initial begin
        left_btn  = 1'b0;
        right_btn = 1'b0;
        restart   = 1'b0;
        Reset     = 1'b0;

        // Reset with left held, then keep holding after release: no move allowed.
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 0);
        cyc(1, 0, 0, 1);
        cyc(1, 0, 0, 1);
        check_eq("reset.leds", 32'(leds0), 32'(9'b000010000));
        check_eq("reset.scores", 32'({ls0, rs0}), 32'd0);
        check_eq("reset.wins", 32'({lw0, rw0}), 32'd0);
        cyc(0, 0, 0, 1);

        for (int i = 0; i < 4; i++) press_left();
        check_eq("left4.leds", 32'(leds0), 32'(9'b100000000));
        press_left();
        check_eq("left5.lwin", 32'(lw0), 32'd1);
        check_eq("left5.lscore", 32'(ls0), 32'd1);
        press_left();
        press_right();
        check_eq("lwin.hold.leds", 32'(leds0), 32'(9'b100000000));
        check_eq("lwin.hold.lscore", 32'(ls0), 32'd1);

        cyc(0, 0, 1, 1);
        check_eq("restart.leds", 32'(leds0), 32'(9'b000010000));
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, 1);
        cyc(0, 0, 0, 1);
        check_eq("hold.one_move", 32'(leds0), 32'(9'b000100000));
        cyc(1, 1, 0, 1);
        cyc(0, 0, 0, 1);
        check_eq("both.no_move", 32'(leds0), 32'(9'b000100000));

        cyc(0, 0, 1, 1);
        for (int i = 0; i < 5; i++) press_right();
        check_eq("wrap.right5.leds", 32'(leds1), 32'(9'b100000000));
        check_eq("wrap.wins", 32'({lw1, rw1}), 32'd0);
        check_eq("rwin.flag", 32'(rw0), 32'd1);
        cyc(0, 0, 1, 1);
        check_eq("rwin.restart.leds", 32'(leds0), 32'(9'b000010000));
        check_eq("rwin.restart.rscore", 32'(rs0), 32'd1);
        check_eq("rwin.restart.rwin", 32'(rw0), 32'd0);
        cyc(0, 0, 0, 0);
        check_eq("reset.clears.scores", 32'({ls0, rs0}), 32'd0);
        cyc(0, 0, 0, 1);

        // Four left wins separated by restart; the 2-bit counter must stop at 3.
        for (int w = 0; w < 4; w++) begin
            for (int i = 0; i < 5; i++) press_left();
            cyc(0, 0, 1, 1);
        end
        check_eq("sat.lscore2", 32'(ls2), 32'd3);
        check_eq("sat.lscore4", 32'(ls0), 32'd4);

        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                $urandom_range(0, 19) == 0, $urandom_range(0, 99) != 0);
        end

        check_eq("sb.drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
